// File: rtl/fetch_controller.sv
// Fetch sequencer between program_counter, instruction ROM and decode.
// One instruction in flight: FETCH, WAIT, HOLD, UPDATE, then the next fetch.
module fetch_controller #(
  parameter int ADDR_W = 11,
  parameter int INSTR_W = 16,
  parameter logic [4:0] OPC_JMP = 5'b10000,
  parameter logic [4:0] OPC_HALT = 5'b11111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_inc,
  output logic               pc_branch_en,
  output logic [ADDR_W-1:0]  pc_branch_addr,
  output logic               imem_ren,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    UPDATE,
    HALT
  } state_t;

  state_t state;

  logic [4:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;

  assign opcode = instr_out[INSTR_W-1 -: 5];
  assign target = instr_out[ADDR_W-1:0];

  // The PC only changes at the end of UPDATE, so the address for the
  // following fetch is the value program_counter is about to take.
  assign pc_next = pc_branch_en ? pc_branch_addr
                                : ADDR_W'(pc_addr + 1'b1);

  // Sequencer with every output registered; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc_inc         <= 1'b0;
      pc_branch_en   <= 1'b0;
      pc_branch_addr <= '0;
      imem_ren       <= 1'b0;
      imem_addr      <= '0;
      instr_out      <= '0;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      halted         <= 1'b0;
    end else begin
      imem_ren       <= 1'b0;
      pc_inc         <= 1'b0;
      pc_branch_en   <= 1'b0;
      pc_branch_addr <= '0;
      unique case (state)
        IDLE: begin
          state     <= FETCH;
          imem_ren  <= 1'b1;
          imem_addr <= pc_addr;
        end
        FETCH: begin
          if (redirect_en) begin
            state          <= UPDATE;
            pc_branch_en   <= 1'b1;
            pc_branch_addr <= redirect_addr;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_en) begin
            state          <= UPDATE;
            pc_branch_en   <= 1'b1;
            pc_branch_addr <= redirect_addr;
          end else begin
            state       <= HOLD;
            instr_out   <= imem_rdata;
            instr_pc    <= pc_addr;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_en) begin
            state          <= UPDATE;
            instr_valid    <= 1'b0;
            pc_branch_en   <= 1'b1;
            pc_branch_addr <= redirect_addr;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (opcode == OPC_HALT) begin
              state  <= HALT;
              halted <= 1'b1;
            end else if (opcode == OPC_JMP) begin
              state          <= UPDATE;
              pc_branch_en   <= 1'b1;
              pc_branch_addr <= target;
            end else begin
              state  <= UPDATE;
              pc_inc <= 1'b1;
            end
          end
        end
        UPDATE: begin
          if (redirect_en) begin
            pc_branch_en   <= 1'b1;
            pc_branch_addr <= redirect_addr;
          end else begin
            state     <= FETCH;
            imem_ren  <= 1'b1;
            imem_addr <= pc_next;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller with a PC and ROM model.
// Expected fetches, deliveries and strobes are queued and checked by a monitor.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pc_addr;
  logic        pc_inc;
  logic        pc_branch_en;
  logic [10:0] pc_branch_addr;
  logic        imem_ren;
  logic [10:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_en;
  logic [10:0] redirect_addr;
  logic        halted;

  fetch_controller dut (
    .clk(clk),
    .rst(rst),
    .pc_addr(pc_addr),
    .pc_inc(pc_inc),
    .pc_branch_en(pc_branch_en),
    .pc_branch_addr(pc_branch_addr),
    .imem_ren(imem_ren),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .instr_out(instr_out),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_en(redirect_en),
    .redirect_addr(redirect_addr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:2047];
  logic [10:0] pc;
  assign pc_addr = pc;

  // program_counter model
  always @(posedge clk) begin
    if (rst) pc <= 11'd0;
    else if (pc_branch_en) pc <= pc_branch_addr;
    else if (pc_inc) pc <= pc + 11'd1;
  end

  // ROM with one cycle read latency
  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= rom[imem_addr];
  end

  logic [10:0] fq[$];
  logic [26:0] dq[$];
  logic [11:0] sq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_d(input logic [10:0] a, input logic [15:0] w);
    dq.push_back({a, w});
  endtask

  // Monitor: pops queued expectations as the DUT presents events.
  always @(negedge clk) begin
    logic [10:0] ef;
    logic [26:0] ed;
    logic [11:0] es;
    checks++;
    if ((pc_inc && pc_branch_en) ||
        (!pc_branch_en && pc_branch_addr != 11'd0)) begin
      errors++;
      $display("FAIL strobe_rules: inc=%0b br=%0b addr=%0d",
               pc_inc, pc_branch_en, pc_branch_addr);
    end
    if (imem_ren) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fetch: got read of %0d, expected none", imem_addr);
      end else begin
        ef = fq.pop_front();
        if (imem_addr !== ef) begin
          errors++;
          $display("FAIL fetch: got %0d, expected %0d", imem_addr, ef);
        end
      end
    end
    if (instr_valid && instr_ready) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL deliver: got pc %0d instr %0h, expected none",
                 instr_pc, instr_out);
      end else begin
        ed = dq.pop_front();
        if ({instr_pc, instr_out} !== ed) begin
          errors++;
          $display("FAIL deliver: got pc %0d instr %0h, expected pc %0d instr %0h",
                   instr_pc, instr_out, ed[26:16], ed[15:0]);
        end
      end
    end
    if (pc_inc || pc_branch_en) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL strobe: got br=%0b addr=%0d, expected none",
                 pc_branch_en, pc_branch_addr);
      end else begin
        es = sq.pop_front();
        if ({pc_branch_en, pc_branch_addr} !== es) begin
          errors++;
          $display("FAIL strobe: got br=%0b addr=%0d, expected br=%0b addr=%0d",
                   pc_branch_en, pc_branch_addr, es[11], es[10:0]);
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    rom[0]   = 16'h0123;
    rom[1]   = 16'h8014;
    rom[20]  = 16'h0200;
    rom[21]  = 16'h0300;
    rom[100] = 16'h0400;
    rom[101] = 16'hF800;
    rst = 1'b1;
    instr_ready = 1'b1;
    redirect_en = 1'b0;
    redirect_addr = 11'd0;

    fq = '{11'd0, 11'd1, 11'd20, 11'd21, 11'd100, 11'd101};
    push_d(11'd0, 16'h0123);
    push_d(11'd1, 16'h8014);
    push_d(11'd20, 16'h0200);
    push_d(11'd100, 16'h0400);
    push_d(11'd101, 16'hF800);
    sq = '{12'h000, {1'b1, 11'd20}, 12'h000, {1'b1, 11'd100}, 12'h000};

    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {imem_ren, pc_inc, pc_branch_en, pc_branch_addr, imem_addr,
         instr_valid, halted}, 32'd0);
    chk("reset_instr", {instr_out, instr_pc}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    n = 0;
    do begin @(negedge clk); n++; end
    while (!(imem_ren && imem_addr == 11'd20) && n < 100);
    chk("fetch20_seen", {31'd0, imem_ren}, 32'd1);
    @(posedge clk);
    #1 instr_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", {5'd0, instr_pc, instr_out}, {5'd0, 11'd20, 16'h0200});
      chk("stall_strobe", {30'd0, pc_inc, pc_branch_en}, 32'd0);
    end
    @(posedge clk);
    #1 instr_ready = 1'b1;

    n = 0;
    do begin @(negedge clk); n++; end
    while (!(imem_ren && imem_addr == 11'd21) && n < 100);
    chk("fetch21_seen", {31'd0, imem_ren}, 32'd1);
    @(posedge clk);
    #1 redirect_en = 1'b1;
    redirect_addr = 11'd100;
    @(posedge clk);
    #1 redirect_en = 1'b0;
    redirect_addr = 11'd0;
    @(negedge clk);
    chk("redirect_no_valid", {31'd0, instr_valid}, 32'd0);

    n = 0;
    do begin @(negedge clk); n++; end
    while (!halted && n < 100);
    chk("halted_reached", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_state", {28'd0, halted, imem_ren, pc_inc, pc_branch_en},
          32'd8);
      redirect_en = (i == 5);
      redirect_addr = (i == 5) ? 11'd5 : 11'd0;
    end
    redirect_en = 1'b0;

    instr_ready = 1'b0;
    fq.push_back(11'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("halt_cleared", {31'd0, halted}, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!instr_valid && n < 100);
    chk("restart_hold", {5'd0, instr_pc, instr_out}, {5'd0, 11'd0, 16'h0123});

    @(posedge clk);
    #1 rst = 1'b1;
    fq.push_back(11'd0);
    fq.push_back(11'd1);
    fq.push_back(11'd20);
    push_d(11'd0, 16'h0123);
    push_d(11'd1, 16'h8014);
    sq.push_back(12'h000);
    sq.push_back({1'b1, 11'd20});
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hold_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b1;

    n = 0;
    do begin @(negedge clk); n++; end
    while ((fq.size() + dq.size() + sq.size()) != 0 && n < 200);
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("queues_drained", fq.size() + dq.size() + sq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
